msg_scroller: RTL and testbench

- Upstream feeder for the 4-digit seven-segment driver: holds a message of up to 16 four-bit glyph codes and presents a 4-glyph window on a 16-bit `data` bus.
- The window advances one glyph every SCROLL_DIV clocks, wrapping around the message.
- Glyph codes are the display driver's codes: 0=O, 1=I, 2=L, 3=H, 4='-', 5=n, 6=U, 7=r, 8=P, 9=g, 10-14=A,b,C,d,E, 15=t.
- Lets the CPU post status words such as "HELLO-" without software timing.

---
 rtl/msg_scroller.sv | 174 +++++++++++++++++
 tb/tb_msg_scroller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/msg_scroller.sv
// msg_scroller: holds up to 16 glyph codes and scrolls a 4-glyph window onto the
// seven-segment driver bus. Define MSG_PAUSE_EN to dwell at position 0 after start and each wrap.
module msg_scroller #(
    parameter int SCROLL_DIV  = 25000000,
    parameter int PAUSE_STEPS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [3:0]  wr_data,
    input  logic [4:0]  msg_len,
    input  logic        start,
    input  logic        stop,
    output logic [15:0] data,
    output logic        busy,
    output logic        wrap
);

    localparam logic [26:0] DIV_LAST = 27'(SCROLL_DIV - 1);

`ifdef MSG_PAUSE_EN
    localparam int          PAUSE_CYC  = PAUSE_STEPS * SCROLL_DIV;
    localparam logic [31:0] PAUSE_LAST = 32'(PAUSE_CYC - 1);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCROLL = 2'd1, S_PAUSE = 2'd2} state_t;
    localparam state_t S_DWELL = (PAUSE_CYC > 0) ? S_PAUSE : S_SCROLL;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCROLL = 2'd1} state_t;
    localparam state_t S_DWELL = S_SCROLL;
`endif

    logic [3:0]  r_buf [16];
    logic [3:0]  r_ptr;
    logic [4:0]  r_len;
    logic [26:0] r_cnt;
    state_t      r_state;
    logic [15:0] r_data;
    logic        r_busy;
    logic        r_wrap;
`ifdef MSG_PAUSE_EN
    logic [31:0] r_pcnt;
`endif

    logic [3:0]  w_i1;
    logic [3:0]  w_i2;
    logic [3:0]  w_i3;
    logic [15:0] w_window;

    // A zero or oversize length means "use the whole buffer".
    function automatic logic [4:0] clamp_len(input logic [4:0] l);
        if (l == 5'd0 || l > 5'd16) begin
            clamp_len = 5'd16;
        end else begin
            clamp_len = l;
        end
    endfunction

    // Successor index modulo len; valid for any len >= 1 because cur < len.
    function automatic logic [3:0] next_idx(input logic [3:0] cur, input logic [4:0] len);
        logic [4:0] inc;
        inc = {1'b0, cur} + 5'd1;
        if (inc == len) begin
            next_idx = 4'd0;
        end else begin
            next_idx = inc[3:0];
        end
    endfunction

    assign data = r_data;
    assign busy = r_busy;
    assign wrap = r_wrap;

    // Window indices, chained so short messages repeat across all four digits.
    always_comb begin
        w_i1     = next_idx(r_ptr, r_len);
        w_i2     = next_idx(w_i1, r_len);
        w_i3     = next_idx(w_i2, r_len);
        w_window = {r_buf[r_ptr], r_buf[w_i1], r_buf[w_i2], r_buf[w_i3]};
    end

    // Message buffer; writes are accepted in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                r_buf[i] <= 4'h4;
            end
        end else if (wr_en) begin
            r_buf[wr_addr] <= wr_data;
        end else begin
            r_buf <= r_buf;
        end
    end

    // Output register for the display bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= 16'h4444;
        end else begin
            r_data <= w_window;
        end
    end

    // Scroll FSM; stop outranks start in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= 4'd0;
            r_len   <= 5'd16;
            r_cnt   <= 27'd0;
            r_busy  <= 1'b0;
            r_wrap  <= 1'b0;
`ifdef MSG_PAUSE_EN
            r_pcnt  <= 32'd0;
`endif
        end else begin
            r_wrap <= 1'b0;
            if (stop) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_cnt   <= 27'd0;
            end else if (start) begin
                r_state <= S_DWELL;
                r_busy  <= 1'b1;
                r_ptr   <= 4'd0;
                r_cnt   <= 27'd0;
                r_len   <= clamp_len(msg_len);
`ifdef MSG_PAUSE_EN
                r_pcnt  <= 32'd0;
`endif
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_busy <= 1'b0;
                    end
                    S_SCROLL: begin
                        if (r_cnt == DIV_LAST) begin
                            r_cnt <= 27'd0;
                            if (r_len <= 5'd4) begin
                                r_ptr <= 4'd0;
                            end else if ({1'b0, r_ptr} == r_len - 5'd1) begin
                                r_ptr   <= 4'd0;
                                r_wrap  <= 1'b1;
                                r_state <= S_DWELL;
`ifdef MSG_PAUSE_EN
                                r_pcnt  <= 32'd0;
`endif
                            end else begin
                                r_ptr <= r_ptr + 4'd1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 27'd1;
                        end
                    end
`ifdef MSG_PAUSE_EN
                    S_PAUSE: begin
                        if (r_pcnt == PAUSE_LAST) begin
                            r_state <= S_SCROLL;
                            r_cnt   <= 27'd0;
                            r_pcnt  <= 32'd0;
                        end else begin
                            r_pcnt <= r_pcnt + 32'd1;
                        end
                    end
`endif
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_msg_scroller.sv
// Self-checking bench for msg_scroller: a time-based reference model (pointer derived
// from elapsed clocks) checked every cycle, plus literal expectations and random traffic.
module tb_msg_scroller;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [3:0]  wr_data;
    logic [4:0]  msg_len;
    logic        start;
    logic        stop;
    logic [15:0] data;
    logic        busy;
    logic        wrap;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic [3:0]  m_buf [16];
    bit          m_run = 1'b0;
    int          m_len = 16;
    int          m_ptr = 0;
    int          m_el  = 0;
    logic [15:0] e_data = 16'h4444;
    logic        e_busy = 1'b0;
    logic        e_wrap = 1'b0;

    logic [3:0] hello [6] = '{4'h3, 4'hE, 4'h2, 4'h2, 4'h0, 4'h4};

    msg_scroller #(.SCROLL_DIV(DIV), .PAUSE_STEPS(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .msg_len (msg_len),
        .start   (start),
        .stop    (stop),
        .data    (data),
        .busy    (busy),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    function automatic int clamp(input logic [4:0] l);
        if (l == 5'd0 || l > 5'd16) return 16;
        return int'(l);
    endfunction

    // Pointer as a function of clocks elapsed since the last start.
    function automatic int cur_ptr();
        if (!m_run) return m_ptr;
        if (m_len <= 4) return 0;
        return (m_el / DIV) % m_len;
    endfunction

    function automatic logic [15:0] window();
        int p;
        logic [15:0] w;
        p = cur_ptr();
        for (int k = 0; k < 4; k++) w[15 - 4*k -: 4] = m_buf[(p + k) % m_len];
        return w;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic pin(input string name, input logic [15:0] want);
        check({name, "_dut"}, data, want);
        check({name, "_model"}, e_data, want);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: expected outputs after each rising edge.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 16; i++) m_buf[i] = 4'h4;
            m_run = 1'b0; m_ptr = 0; m_len = 16; m_el = 0;
            e_data = 16'h4444; e_busy = 1'b0; e_wrap = 1'b0;
        end else begin
            e_data = window();
            e_wrap = 1'b0;
            if (m_run && stop) begin
                m_ptr = cur_ptr();
                m_run = 1'b0;
            end else if (start && !stop) begin
                m_run = 1'b1; m_len = clamp(msg_len); m_el = 0; m_ptr = 0;
            end else if (m_run) begin
                m_el++;
                if (m_len > 4 && (m_el % (DIV * m_len)) == 0) e_wrap = 1'b1;
            end
            if (wr_en) m_buf[wr_addr] = wr_data;
            e_busy = m_run;
        end
    end

    // Every-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("data", data, e_data);
            check("busy", {15'd0, busy}, {15'd0, e_busy});
            check("wrap", {15'd0, wrap}, {15'd0, e_wrap});
        end
    end

    initial begin
        int wraps;
        rst = 1'b1; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 4'd0;
        msg_len = 5'd0; start = 1'b0; stop = 1'b0;
        tick(1);
        chk_en = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(10);
        pin("reset_hold", 16'h4444);
        check("reset_busy", {15'd0, busy}, 16'd0);

        // HELLO- scrolling
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = hello[i];
            tick(1);
        end
        wr_en = 1'b0; msg_len = 5'd6; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        pin("hello_p0", 16'h3E22);
        tick(4); pin("hello_p1", 16'hE220);
        tick(4); pin("hello_p2", 16'h2204);
        tick(4); pin("hello_p3", 16'h2043);
        tick(10); check("wrap_early", {15'd0, wrap}, 16'd0);
        tick(1);  check("wrap_pulse", {15'd0, wrap}, 16'd1);
        check("wrap_pulse_model", {15'd0, e_wrap}, 16'd1);
        tick(1);  check("wrap_end", {15'd0, wrap}, 16'd0);
        pin("hello_wrapped", 16'h3E22);

        // Stop at ptr 3, start+stop together, then plain restart
        start = 1'b1; tick(1); start = 1'b0;
        tick(13);
        stop = 1'b1; tick(1); stop = 1'b0;
        check("stop_busy", {15'd0, busy}, 16'd0);
        pin("stop_frozen", 16'h2043);
        tick(5); pin("stop_hold", 16'h2043);
        start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0;
        check("both_busy", {15'd0, busy}, 16'd0);
        tick(3); pin("both_hold", 16'h2043);
        start = 1'b1; tick(1); start = 1'b0;
        check("restart_busy", {15'd0, busy}, 16'd1);
        tick(1); pin("restart_p0", 16'h3E22);

        // Write to the displayed glyph while scrolling
        wr_en = 1'b1; wr_addr = 4'(cur_ptr()); wr_data = 4'hF;
        tick(1); wr_en = 1'b0;
        tick(1); pin("live_write", 16'hFE22);

        // Reset mid-scroll
        tick(6);
        rst = 1'b1; tick(1); rst = 1'b0;
        pin("mid_reset", 16'h4444);
        check("mid_reset_busy", {15'd0, busy}, 16'd0);

        // Short message: static, no wrap
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 4'h1; tick(1);
        wr_addr = 4'd1; wr_data = 4'h5; tick(1);
        wr_en = 1'b0; msg_len = 5'd2; start = 1'b1; tick(1); start = 1'b0;
        tick(1); pin("len2", 16'h1515);
        check("len2_busy", {15'd0, busy}, 16'd1);
        wraps = 0;
        for (int c = 0; c < 24; c++) begin
            tick(1);
            if (wrap) wraps++;
        end
        check("len2_nowrap", 16'(wraps), 16'd0);
        pin("len2_static", 16'h1515);

        // len 1 repeats one glyph; len 0 means 16
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 4'h9; tick(1); wr_en = 1'b0;
        msg_len = 5'd1; start = 1'b1; tick(1); start = 1'b0;
        tick(1); pin("len1", 16'h9999);
        msg_len = 5'd0; start = 1'b1; tick(1); start = 1'b0;
        tick(1); pin("len0_p0", 16'h9544);
        tick(4); pin("len0_p1", 16'h5444);

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            rst     = ($urandom_range(0, 299) == 0);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = 4'($urandom_range(0, 15));
            msg_len = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 31))
                                                  : 5'($urandom_range(4, 7));
            start   = ($urandom_range(0, 149) == 0);
            stop    = ($urandom_range(0, 199) == 0);
            tick(1);
        end
        rst = 1'b0; wr_en = 1'b0; start = 1'b0; stop = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
